// File: rtl/cache_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter_if
//
// Line-granular memory port bundle. Used both between a cache and the
// arbiter, and between the arbiter and the memory model / burst adapter.
//
//   addr   requester -> responder  line address
//   read   requester -> responder  refill request / command
//   write  requester -> responder  write-back request / command
//   wdata  requester -> responder  write-back line
//   rdata  responder -> requester  refill line, valid with resp
//   resp   responder -> requester  one-cycle completion pulse
//
// Modports: master = requester side, slave = responder side.
// ---------------------------------------------------------------------------
interface cache_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  read;
    logic                  write;
    logic [LINE_WIDTH-1:0] wdata;
    logic [LINE_WIDTH-1:0] rdata;
    logic                  resp;

    modport master (output addr, read, write, wdata, input  rdata, resp);
    modport slave  (input  addr, read, write, wdata, output rdata, resp);
endinterface

// File: rtl/cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter
//
// Shares one line-granular memory port (dfp) between the instruction cache
// (client 0) and the data cache (client 1). A winning request is latched into
// the dfp registers, held until dfp.resp, and the response is routed back to
// the granted client. One transaction is outstanding at a time.
//
// Ports:
//   clk       single clock, rising edge
//   rst       asynchronous, active-high reset
//   c0        slave port from the icache
//   c1        slave port from the dcache
//   dfp       master port to memory (addr/read/write/wdata registered)
//   busy      a transaction is outstanding
//   grant_id  client owning dfp, valid while busy
//
// Configuration macro:
//   CACHE_ARB_RR_EN  defined   -> round-robin on ties (last-served pointer)
//                    undefined -> fixed priority, client 1 wins ties
// ---------------------------------------------------------------------------
module cache_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    cache_mem_arbiter_if.slave         c0,
    cache_mem_arbiter_if.slave         c1,
    cache_mem_arbiter_if.master        dfp,
    output logic                       busy,
    output logic                       grant_id
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                state;
    logic                  req0;
    logic                  req1;
    logic                  win;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_read;
    logic                  sel_write;
    logic [LINE_WIDTH-1:0] sel_wdata;

    assign req0 = c0.read | c0.write;
    assign req1 = c1.read | c1.write;

`ifdef CACHE_ARB_RR_EN
    logic last_served;

    // On a tie the client that was not served last wins.
    assign win = req1 & (~req0 | ~last_served);
`else
    assign win = req1;
`endif

    // Winner's request; read has precedence over write on an illegal dual request.
    always_comb begin
        sel_addr  = win ? c1.addr  : c0.addr;
        sel_wdata = win ? c1.wdata : c0.wdata;
        sel_read  = win ? c1.read  : c0.read;
        sel_write = (win ? c1.write : c0.write) & ~sel_read;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dfp.addr  <= '0;
            dfp.read  <= 1'b0;
            dfp.write <= 1'b0;
            dfp.wdata <= '0;
            grant_id  <= 1'b0;
`ifdef CACHE_ARB_RR_EN
            last_served <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        dfp.addr  <= sel_addr;
                        dfp.read  <= sel_read;
                        dfp.write <= sel_write;
                        dfp.wdata <= sel_wdata;
                        grant_id  <= win;
`ifdef CACHE_ARB_RR_EN
                        last_served <= win;
`endif
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    // Client inputs are not looked at here, so the request still
                    // held in the dfp.resp cycle cannot cause a regrant.
                    if (dfp.resp) begin
                        dfp.read  <= 1'b0;
                        dfp.write <= 1'b0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = (state == BUSY);

    // Completion is routed combinationally; a resp seen in IDLE is dropped.
    assign c0.resp  = busy & dfp.resp & ~grant_id;
    assign c1.resp  = busy & dfp.resp &  grant_id;

    // Broadcast: only the client with resp high consumes the line.
    assign c0.rdata = dfp.rdata;
    assign c1.rdata = dfp.rdata;

    // A client must never raise read and write together.
    c0_one_cmd: assert property (@(posedge clk) disable iff (rst) !(c0.read && c0.write));
    c1_one_cmd: assert property (@(posedge clk) disable iff (rst) !(c1.read && c1.write));

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_mem_arbiter
//
// Self-checking bench for cache_mem_arbiter. Two client agents and a memory
// responder are driven from the bench; a transaction-level reference model
// predicts grants, the latched dfp command and the routed responses.
// Inputs for a cycle are applied at the falling edge, outputs are sampled
// 1 ns later, and the model then predicts the effect of the next rising edge.
// ---------------------------------------------------------------------------
module tb_cache_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic grant_id;

    cache_mem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) c0_if ();
    cache_mem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) c1_if ();
    cache_mem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dfp_if ();

    cache_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk      (clk),
        .rst      (rst),
        .c0       (c0_if),
        .c1       (c1_if),
        .dfp      (dfp_if),
        .busy     (busy),
        .grant_id (grant_id)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Client agents: the request each client is currently presenting.
    logic [AW-1:0] a_addr  [2];
    logic          a_rd    [2];
    logic          a_wr    [2];
    logic [LW-1:0] a_wdata [2];
    bit            a_hold  [2];   // keep requesting after resp
    bit            a_done  [2];   // resp seen: drop request next cycle

    // Reference model: one outstanding transaction and its latched command.
    bit            m_busy;
    bit            m_gnt;
    bit            m_last;
    logic [AW-1:0] m_addr;
    bit            m_rd;
    bit            m_wr;
    logic [LW-1:0] m_wdata;
    int            glog[$];       // grant order

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic drive_clients();
        c0_if.addr = a_addr[0]; c0_if.read = a_rd[0]; c0_if.write = a_wr[0]; c0_if.wdata = a_wdata[0];
        c1_if.addr = a_addr[1]; c1_if.read = a_rd[1]; c1_if.write = a_wr[1]; c1_if.wdata = a_wdata[1];
    endtask

    task automatic model_reset();
        m_busy = 0; m_gnt = 0; m_last = 1; m_rd = 0; m_wr = 0;
        a_done[0] = 0; a_done[1] = 0;
    endtask

    // One clock cycle: apply inputs, check outputs, advance the model.
    task automatic step(input bit dresp);
        logic [LW-1:0] rd;
        bit r0, r1, win, e0, e1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (a_done[i]) begin
                if (!a_hold[i]) begin a_rd[i] = 0; a_wr[i] = 0; end
                a_done[i] = 0;
            end
        end
        rd = rand_line();
        drive_clients();
        dfp_if.resp  = dresp;
        dfp_if.rdata = rd;
        #1;
        check("busy", busy, m_busy);
        check("dfp_read", dfp_if.read, m_busy & m_rd);
        check("dfp_write", dfp_if.write, m_busy & m_wr);
        if (m_busy) begin
            check("grant_id", grant_id, m_gnt);
            check("dfp_addr", dfp_if.addr, m_addr);
            check("dfp_wdata", dfp_if.wdata, m_wdata);
        end
        e0 = m_busy && dresp && (m_gnt == 0);
        e1 = m_busy && dresp && (m_gnt == 1);
        check("c0_resp", c0_if.resp, e0);
        check("c1_resp", c1_if.resp, e1);
        check("c0_rdata", c0_if.rdata, rd);
        check("c1_rdata", c1_if.rdata, rd);

        if (m_busy) begin
            if (dresp) begin
                m_busy = 0;
                a_done[m_gnt] = 1;
            end
        end else begin
            r0 = a_rd[0] | a_wr[0];
            r1 = a_rd[1] | a_wr[1];
            if (r0 | r1) begin
`ifdef CACHE_ARB_RR_EN
                win = (r0 && r1) ? !m_last : r1;
`else
                win = r1;
`endif
                m_busy  = 1;
                m_gnt   = win;
                m_last  = win;
                m_addr  = a_addr[win];
                m_rd    = a_rd[win];
                m_wr    = a_wr[win] && !a_rd[win];
                m_wdata = a_wdata[win];
                glog.push_back(int'(win));
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        a_hold[0] = 0; a_hold[1] = 0;
        while ((m_busy || a_rd[0] || a_wr[0] || a_rd[1] || a_wr[1]) && n < 200) begin
            step(m_busy);
            n++;
        end
        if (n >= 200) check("drain_timeout", n, 0);
        step(0);
        check("drain_idle", {busy, dfp_if.read, dfp_if.write}, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        #1;
        model_reset();
        @(posedge clk);
        #2 rst = 0;
    endtask

    int            exp_order[4];
    int            n;
    int            age;
    int            lat;
    int            zeros;
    int            gaps;
    bit            seen_one;
    bit            dr;
    bit            was;
    bit            rd_trace[$];

    initial begin
        for (int i = 0; i < 2; i++) begin
            a_addr[i] = '0; a_rd[i] = 0; a_wr[i] = 0; a_wdata[i] = '0;
            a_hold[i] = 0; a_done[i] = 0;
        end
        drive_clients();
        dfp_if.resp  = 1'b1;
        dfp_if.rdata = '0;
        model_reset();

        // Reset values, with dfp.resp forced high to show no resp leaks out.
        #13;
        check("rst_busy", busy, 0);
        check("rst_dfp_read", dfp_if.read, 0);
        check("rst_dfp_write", dfp_if.write, 0);
        check("rst_dfp_addr", dfp_if.addr, 0);
        check("rst_dfp_wdata", dfp_if.wdata, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_c0_resp", c0_if.resp, 0);
        check("rst_c1_resp", c1_if.resp, 0);
        dfp_if.resp = 1'b0;
        @(posedge clk);
        #2 rst = 0;

        // Single refill from c0, memory answers 5 cycles after the grant.
        a_addr[0] = 32'h0000_1000; a_rd[0] = 1;
        step(0);
        step(0);
        check("t1_dfp_read", dfp_if.read, 1);
        check("t1_dfp_addr", dfp_if.addr, 32'h0000_1000);
        repeat (3) step(0);
        step(1);
        check("t1_c0_resp", c0_if.resp, 1);
        check("t1_c1_resp", c1_if.resp, 0);
        step(0);

        // Write-back from c1; its wdata changes after the grant.
        a_addr[1] = 32'h8000_0040; a_wr[1] = 1; a_wdata[1] = {32{8'hA5}};
        step(0);
        a_wdata[1] = {32{8'h5A}};
        repeat (3) step(0);
        check("t2_wdata_held", dfp_if.wdata, {32{8'hA5}});
        check("t2_dfp_write", dfp_if.write, 1);
        step(1);
        check("t2_c1_resp", c1_if.resp, 1);
        step(0);

        // Spurious memory response while idle.
        step(1);
        step(1);
        check("t4_spurious_c0", c0_if.resp, 0);
        check("t4_spurious_c1", c1_if.resp, 0);
        check("t4_still_idle", busy, 0);

        // Simultaneous requests from reset.
        do_reset();
        a_addr[0] = 32'h0000_0100; a_rd[0] = 1;
        a_addr[1] = 32'h0000_0200; a_rd[1] = 1;
`ifdef CACHE_ARB_RR_EN
        a_hold[0] = 1; a_hold[1] = 1;
        exp_order = '{0, 1, 0, 1};
`else
        a_hold[0] = 1; a_hold[1] = 0;
        exp_order = '{1, 0, 0, 0};
`endif
        glog.delete();
        n = 0;
        while (glog.size() < 4 && n < 100) begin
            step(m_busy);
            n++;
        end
        if (glog.size() < 4) check("t3_timeout", glog.size(), 4);
        for (int k = 0; k < 4 && k < glog.size(); k++) check("t3_grant_order", glog[k], exp_order[k]);
        drain();

        // Reset two cycles after a grant, c0 keeps requesting.
        a_addr[0] = 32'h0000_2000; a_rd[0] = 1; a_wr[0] = 0;
        step(0);
        step(0);
        step(0);
        dfp_if.resp = 1'b1;
        #1;
        check("t5_pre_c0_resp", c0_if.resp, 1);
        rst = 1;
        #1;
        check("t5_dfp_read", dfp_if.read, 0);
        check("t5_busy", busy, 0);
        check("t5_c0_resp", c0_if.resp, 0);
        check("t5_c1_resp", c1_if.resp, 0);
        check("t5_dfp_addr", dfp_if.addr, 0);
        model_reset();
        dfp_if.resp = 1'b0;
        @(posedge clk);
        #2 rst = 0;
        step(0);
        step(0);
        check("t5_regrant", dfp_if.read, 1);
        check("t5_regrant_addr", dfp_if.addr, 32'h0000_2000);
        drain();

        // Back-to-back requests from c0.
        a_addr[0] = 32'h0000_3000; a_rd[0] = 1; a_hold[0] = 1;
        rd_trace.delete();
        age = 0;
        repeat (14) begin
            dr = m_busy && age >= 2;
            step(dr);
            rd_trace.push_back(dfp_if.read);
            age = m_busy ? age + 1 : 0;
        end
        zeros = 0; gaps = 0; seen_one = 0;
        foreach (rd_trace[k]) begin
            if (rd_trace[k]) begin
                if (seen_one && zeros > 0) begin
                    check("t6_idle_gap", zeros, 1);
                    gaps++;
                end
                seen_one = 1;
                zeros = 0;
            end else begin
                zeros++;
            end
        end
        check("t6_gap_seen", gaps >= 2, 1);
        drain();

        // Randomised traffic from both clients with random memory latency.
        lat = 0;
        repeat (3000) begin
            for (int i = 0; i < 2; i++) begin
                if (!a_rd[i] && !a_wr[i] && !a_done[i] && $urandom_range(0, 3) == 0) begin
                    a_addr[i]  = $urandom() & ~32'h1F;
                    a_wr[i]    = $urandom_range(0, 1) == 1;
                    a_rd[i]    = !a_wr[i];
                    a_wdata[i] = rand_line();
                    a_hold[i]  = 0;
                end
            end
            if (m_busy && $urandom_range(0, 3) == 0) a_wdata[m_gnt] = rand_line();
            if (m_busy) begin
                dr = (lat == 0);
                if (lat > 0) lat--;
            end else begin
                dr = ($urandom_range(0, 7) == 0);
            end
            was = m_busy;
            step(dr);
            if (!was && m_busy) lat = $urandom_range(0, 3);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
